// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the memory port arbiter
//
// Purpose: types shared by the memory port arbiter and its round-robin picker.
// Contents:
//   rv32i_word   - basic data/address word
//   arb_state_t  - arbiter FSM state {IDLE, GRANT}
//   arb_owner_t  - which initiator port owns the downstream port {INST, DATA}
//   mem_req_t    - latched downstream request (read, write, be, address, wdata)
//   make_req     - builds a mem_req_t; when read and write are both set it
//                  produces a write

package mem_port_arbiter_pkg;

    localparam int MEM_WIDTH    = 32;
    localparam int MEM_BE_WIDTH = MEM_WIDTH / 8;

    typedef logic [MEM_WIDTH-1:0]    rv32i_word;
    typedef logic [MEM_BE_WIDTH-1:0] rv32i_be;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic      read;
        logic      write;
        rv32i_be   be;
        rv32i_word address;
        rv32i_word wdata;
    } mem_req_t;

    function automatic mem_req_t make_req(
        input logic      read,
        input logic      write,
        input rv32i_be   be,
        input rv32i_word address,
        input rv32i_word wdata
    );
        mem_req_t r;
        r.write   = write;
        r.read    = read & ~write;
        r.be      = be;
        r.address = address;
        r.wdata   = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rtl/mem_port_arbiter_rr_arbiter2.sv - two-way round-robin picker
//
// Purpose: chooses one of two requesters. A lone requester always wins; when
// both request, the one that did not win last time is chosen.
// Ports:
//   req[0]  in   INST port requesting
//   req[1]  in   DATA port requesting
//   last    in   owner of the previous grant
//   grant   out  chosen owner (meaningful only when req != 0)

module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_t last,
    output arb_owner_t grant
);

    always_comb begin
        grant = INST;
        if (req == 2'b11) begin
            grant = (last == INST) ? DATA : INST;
        end else if (req[1]) begin
            grant = DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and LSQ memory ports onto one port
//
// Purpose: responder for the instruction-fetch (i_mem_*) and load/store queue
// (lsq_mem_*) memory ports; forwards one request at a time to the downstream
// memory/cache port (mem_*) with round-robin arbitration.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_mem_read/write/byte_enable/address/wdata    fetch request (held until resp)
//   i_mem_resp, i_mem_rdata       fetch completion pulse and read data
//   lsq_mem_read/write/byte_enable/address/wdata  LSQ request (held until resp)
//   lsq_mem_resp, lsq_mem_rdata   LSQ completion pulse and read data
//   mem_read/write/byte_enable/address/wdata      downstream request
//   mem_resp, mem_rdata           downstream completion pulse and read data
// The width parameter must match MEM_WIDTH in the package, since the latched
// request uses the package struct.

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int width = MEM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [width/8-1:0] i_mem_byte_enable,
    input  logic [width-1:0]   i_mem_address,
    input  logic [width-1:0]   i_mem_wdata,
    output logic               i_mem_resp,
    output logic [width-1:0]   i_mem_rdata,

    input  logic               lsq_mem_read,
    input  logic               lsq_mem_write,
    input  logic [width/8-1:0] lsq_mem_byte_enable,
    input  logic [width-1:0]   lsq_mem_address,
    input  logic [width-1:0]   lsq_mem_wdata,
    output logic               lsq_mem_resp,
    output logic [width-1:0]   lsq_mem_rdata,

    output logic               mem_read,
    output logic               mem_write,
    output logic [width/8-1:0] mem_byte_enable,
    output logic [width-1:0]   mem_address,
    output logic [width-1:0]   mem_wdata,
    input  logic               mem_resp,
    input  logic [width-1:0]   mem_rdata
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q;
    arb_owner_t last_grant_q;
    arb_owner_t winner;
    mem_req_t   req_q;
    mem_req_t   winner_req;
    logic [1:0] port_req;
    logic       load_req;
    logic       done_req;
    logic       resp_fire;

    assign port_req = {lsq_mem_read | lsq_mem_write, i_mem_read | i_mem_write};

    rr_arbiter2 u_rr_arbiter2 (
        .req   (port_req),
        .last  (last_grant_q),
        .grant (winner)
    );

    always_comb begin
        winner_req = make_req(i_mem_read, i_mem_write, i_mem_byte_enable,
                              i_mem_address, i_mem_wdata);
        if (winner == DATA) begin
            winner_req = make_req(lsq_mem_read, lsq_mem_write, lsq_mem_byte_enable,
                                  lsq_mem_address, lsq_mem_wdata);
        end
    end

    // Requester lines are only looked at in IDLE; in GRANT the latched copy
    // alone drives the downstream port.
    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        done_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (port_req != 2'b00) begin
                    load_req = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (mem_resp) begin
                    done_req = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // req_q is cleared on completion so every mem_* output reads 0 in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= INST;
            last_grant_q <= INST;
            req_q        <= '0;
        end else begin
            state_q <= state_d;
            if (load_req) begin
                req_q        <= winner_req;
                owner_q      <= winner;
                last_grant_q <= winner;
            end else if (done_req) begin
                req_q <= '0;
            end
        end
    end

    assign mem_read        = req_q.read;
    assign mem_write       = req_q.write;
    assign mem_byte_enable = req_q.be;
    assign mem_address     = req_q.address;
    assign mem_wdata       = req_q.wdata;

    // A completion that coincides with reset is dropped along with the request.
    assign resp_fire     = (state_q == GRANT) & mem_resp & ~rst;
    assign i_mem_resp    = resp_fire & (owner_q == INST);
    assign lsq_mem_resp  = resp_fire & (owner_q == DATA);
    assign i_mem_rdata   = i_mem_resp   ? mem_rdata : '0;
    assign lsq_mem_rdata = lsq_mem_resp ? mem_rdata : '0;

    // Read and write together on one port is illegal; the write is kept.
    a_inst_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(i_mem_read && i_mem_write));
    a_lsq_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(lsq_mem_read && lsq_mem_write));

endmodule
